// File: rtl/led_fade_pwm_pkg.sv
// Shared definitions for the LED fade/PWM driver: one-hot channel state
// encodings and the counter-width helpers used by the top and the channels.
package led_fade_pwm_pkg;

    // One-hot channel states
    localparam logic [3:0] ST_OFF  = 4'b0001;
    localparam logic [3:0] ST_RISE = 4'b0010;
    localparam logic [3:0] ST_ON   = 4'b0100;
    localparam logic [3:0] ST_FALL = 4'b1000;

    // Bits needed for a counter that runs 0..n-1 (at least one bit)
    function automatic int unsigned cnt_w(input int unsigned n);
        if (n <= 32'd1) begin
            return 32'd1;
        end else begin
            return $clog2(n);
        end
    endfunction

    // Bits needed to hold a duty value 0..levels inclusive
    function automatic int unsigned duty_w(input int unsigned levels);
        return cnt_w(levels + 32'd1);
    endfunction

endpackage

// File: rtl/led_fade_pwm_ch.sv
// One LED channel: OFF/RISE/ON/FALL state machine, linear duty ramp stepped
// by the shared fade tick, and a registered PWM compare against pwm_cnt.
module led_fade_pwm_ch
    import led_fade_pwm_pkg::*;
#(
    parameter int unsigned LEVELS = 100,
    parameter int unsigned DUTY_W = duty_w(LEVELS),
    parameter int unsigned PWM_W  = cnt_w(LEVELS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tgt,
    input  logic             fade_tick,
    input  logic [PWM_W-1:0] pwm_cnt,
    output logic             pwm,
    output logic             fading
);

    localparam logic [DUTY_W-1:0] DUTY_MAX  = DUTY_W'(LEVELS);
    localparam logic [DUTY_W-1:0] DUTY_ZERO = {DUTY_W{1'b0}};
    localparam logic [DUTY_W-1:0] DUTY_ONE  = DUTY_W'(1);

    logic [3:0]        state_q, state_d;
    logic [DUTY_W-1:0] duty_q,  duty_d;
    logic              pwm_q,   pwm_d;
    logic [DUTY_W-1:0] pwm_cnt_ext_s;

    // Next state: target level decides direction, duty limits end the fade
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OFF: begin
                if (tgt) begin
                    state_d = ST_RISE;
                end else begin
                    state_d = ST_OFF;
                end
            end
            ST_RISE: begin
                if (!tgt) begin
                    state_d = ST_FALL;
                end else if (duty_q == DUTY_MAX) begin
                    state_d = ST_ON;
                end else begin
                    state_d = ST_RISE;
                end
            end
            ST_ON: begin
                if (!tgt) begin
                    state_d = ST_FALL;
                end else begin
                    state_d = ST_ON;
                end
            end
            ST_FALL: begin
                if (tgt) begin
                    state_d = ST_RISE;
                end else if (duty_q == DUTY_ZERO) begin
                    state_d = ST_OFF;
                end else begin
                    state_d = ST_FALL;
                end
            end
            default: begin
                // Corrupted one-hot code: park the channel dark
                state_d = ST_OFF;
            end
        endcase
    end

    // Duty step: driven by the registered state only, so a same-cycle tgt
    // change never alters the step taken on this fade tick
    always_comb begin
        duty_d = duty_q;
        if (fade_tick) begin
            case (state_q)
                ST_RISE: begin
                    if (duty_q < DUTY_MAX) begin
                        duty_d = duty_q + DUTY_ONE;
                    end else begin
                        duty_d = duty_q;
                    end
                end
                ST_FALL: begin
                    if (duty_q != DUTY_ZERO) begin
                        duty_d = duty_q - DUTY_ONE;
                    end else begin
                        duty_d = duty_q;
                    end
                end
                default: begin
                    duty_d = duty_q;
                end
            endcase
        end else begin
            duty_d = duty_q;
        end
    end

    // PWM compare at full duty width so duty == LEVELS is solidly on
    always_comb begin
        pwm_cnt_ext_s = DUTY_W'(pwm_cnt);
        pwm_d         = (pwm_cnt_ext_s < duty_q);
    end

    // Channel state, duty and PWM output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_OFF;
            duty_q  <= DUTY_ZERO;
            pwm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            pwm_q   <= pwm_d;
        end
    end

    assign pwm    = pwm_q;
    assign fading = (state_q == ST_RISE) || (state_q == ST_FALL);

endmodule

// File: rtl/led_fade_pwm.sv
// LED fade/PWM driver: shared PWM/fade timebase, four fading channels and
// a registered busy flag raised while any channel is mid-fade.
module led_fade_pwm
    import led_fade_pwm_pkg::*;
#(
    parameter int unsigned LEVELS   = 100,
    parameter int unsigned PWM_DIV  = 5,
    parameter int unsigned FADE_DIV = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] led_in,
    output logic [3:0] led_pwm,
    output logic       busy
);

    localparam int unsigned DIV_W  = cnt_w(PWM_DIV);
    localparam int unsigned PWM_W  = cnt_w(LEVELS);
    localparam int unsigned FADE_W = cnt_w(FADE_DIV);
    localparam int unsigned DUTY_W = duty_w(LEVELS);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(PWM_DIV - 1);
    localparam logic [PWM_W-1:0]  PWM_LAST  = PWM_W'(LEVELS - 1);
    localparam logic [FADE_W-1:0] FADE_LAST = FADE_W'(FADE_DIV - 1);

    logic [DIV_W-1:0]  div_cnt_q,  div_cnt_d;
    logic [PWM_W-1:0]  pwm_cnt_q,  pwm_cnt_d;
    logic [FADE_W-1:0] fade_cnt_q, fade_cnt_d;
    logic              busy_q,     busy_d;
    logic              pwm_tick_s;
    logic              pwm_wrap_s;
    logic              fade_tick_s;
    logic [3:0]        pwm_s;
    logic [3:0]        fading_s;

    // Tick decode from the current counter values
    always_comb begin
        pwm_tick_s  = (div_cnt_q == DIV_LAST);
        pwm_wrap_s  = pwm_tick_s && (pwm_cnt_q == PWM_LAST);
        fade_tick_s = pwm_wrap_s && (fade_cnt_q == FADE_LAST);
    end

    // Next values of the prescaler, PWM phase and fade divider
    always_comb begin
        if (pwm_tick_s) begin
            div_cnt_d = {DIV_W{1'b0}};
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end

        if (pwm_wrap_s) begin
            pwm_cnt_d = {PWM_W{1'b0}};
        end else if (pwm_tick_s) begin
            pwm_cnt_d = pwm_cnt_q + 1'b1;
        end else begin
            pwm_cnt_d = pwm_cnt_q;
        end

        if (fade_tick_s) begin
            fade_cnt_d = {FADE_W{1'b0}};
        end else if (pwm_wrap_s) begin
            fade_cnt_d = fade_cnt_q + 1'b1;
        end else begin
            fade_cnt_d = fade_cnt_q;
        end
    end

    // Busy while any channel is rising or falling
    always_comb begin
        busy_d = |fading_s;
    end

    // Timebase and busy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q  <= {DIV_W{1'b0}};
            pwm_cnt_q  <= {PWM_W{1'b0}};
            fade_cnt_q <= {FADE_W{1'b0}};
            busy_q     <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            pwm_cnt_q  <= pwm_cnt_d;
            fade_cnt_q <= fade_cnt_d;
            busy_q     <= busy_d;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_ch
        led_fade_pwm_ch #(
            .LEVELS (LEVELS),
            .DUTY_W (DUTY_W),
            .PWM_W  (PWM_W)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .tgt       (led_in[gi]),
            .fade_tick (fade_tick_s),
            .pwm_cnt   (pwm_cnt_q),
            .pwm       (pwm_s[gi]),
            .fading    (fading_s[gi])
        );
    end

    assign led_pwm = pwm_s;
    assign busy    = busy_q;

endmodule
